// File: rtl/mode_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mode_fsm_pkg
//  Purpose  : Shared mode encoding and one-hot switch decoder for the mode
//             controller, LED display stage and per-mode datapath blocks.
//  Revision : 1.0 - initial release
// ============================================================================
package mode_fsm_pkg;

    localparam int MODE_W = 3;
    localparam int SW_W   = 5;

    typedef enum logic [MODE_W-1:0] {
        MODE_DEFAULT = 3'd0,
        MODE_STORE   = 3'd1,
        MODE_GEN     = 3'd2,
        MODE_SHOW    = 3'd3,
        MODE_CALC    = 3'd4,
        MODE_SETUP   = 3'd5
    } mode_e;

    // Returns the selected mode for a one-hot switch pattern; any other
    // pattern (zero or multi-bit) yields MODE_DEFAULT, meaning "invalid".
    function automatic mode_e decode_sw(input logic [SW_W-1:0] sw);
        case (sw)
            5'b00001: return MODE_STORE;
            5'b00010: return MODE_GEN;
            5'b00100: return MODE_SHOW;
            5'b01000: return MODE_CALC;
            5'b10000: return MODE_SETUP;
            default:  return MODE_DEFAULT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mode_fsm_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mode_fsm_blink_timer
//  Purpose  : Timed error indicator. On start, raises active with blink=1,
//             toggles blink every BLINK_HALF cycles and self-clears after
//             ERR_TOGGLES toggles. Cancel clears immediately.
//  Revision : 1.0 - initial release
// ============================================================================
module mode_fsm_blink_timer #(
    parameter int BLINK_HALF  = 50_000_000,
    parameter int ERR_TOGGLES = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic cancel_i,
    output logic blink_o,
    output logic active_o
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = (ERR_TOGGLES > 0) ? $clog2(ERR_TOGGLES + 1) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(ERR_TOGGLES - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          blink_q, blink_d;
    logic          active_q, active_d;

    // Next-state: cancel beats start; the last wrap ends the error and
    // forces blink low on the same edge instead of toggling it.
    always_comb begin
        cyc_d    = cyc_q;
        tog_d    = tog_q;
        blink_d  = blink_q;
        active_d = active_q;
        if (cancel_i) begin
            cyc_d    = '0;
            tog_d    = '0;
            blink_d  = 1'b0;
            active_d = 1'b0;
        end else if (start_i) begin
            cyc_d    = '0;
            tog_d    = '0;
            blink_d  = 1'b1;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (tog_q == TOG_LAST) begin
                    tog_d    = '0;
                    blink_d  = 1'b0;
                    active_d = 1'b0;
                end else begin
                    tog_d   = tog_q + TW'(1);
                    blink_d = ~blink_q;
                end
            end else begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    // Counter and phase registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            tog_q    <= '0;
            blink_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            tog_q    <= tog_d;
            blink_q  <= blink_d;
            active_q <= active_d;
        end
    end

    assign blink_o  = blink_q & active_q;
    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mode_fsm
//  Purpose  : Top-level mode controller. Decodes one-hot mode switches on
//             confirm, tracks the active mode, handles deferred exit while
//             the mode block is busy, and drives a timed blinking error on
//             invalid selections.
//  Revision : 1.0 - initial release
// ============================================================================
module mode_fsm
    import mode_fsm_pkg::*;
#(
    parameter int BLINK_HALF  = 50_000_000,
    parameter int ERR_TOGGLES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   mode_sw,
    input  logic              confirm_pulse,
    input  logic              back_pulse,
    input  logic              sub_busy,
    output logic [MODE_W-1:0] mode_state,
    output logic              error_active,
    output logic              blink_bit,
    output logic              mode_enter,
    output logic              mode_exit
);

    mode_e mode_q, mode_d;
    logic  pend_q, pend_d;
    logic  enter_q, enter_d;
    logic  exit_q, exit_d;
    logic  w_err_start;
    logic  w_err_cancel;
    logic  w_err_active;
    logic  w_err_blink;
    mode_e w_sel;

    assign w_sel = decode_sw(mode_sw);

    // Next-state and pulse decode; back always wins over confirm in DEFAULT.
    always_comb begin
        mode_d       = mode_q;
        pend_d       = pend_q;
        enter_d      = 1'b0;
        exit_d       = 1'b0;
        w_err_start  = 1'b0;
        w_err_cancel = 1'b0;
        case (mode_q)
            MODE_DEFAULT: begin
                pend_d = 1'b0;
                if (back_pulse) begin
                    w_err_cancel = 1'b1;
                end else if (confirm_pulse && !w_err_active) begin
                    if (w_sel != MODE_DEFAULT) begin
                        mode_d  = w_sel;
                        enter_d = 1'b1;
                    end else begin
                        w_err_start = 1'b1;
                    end
                end
            end
            MODE_STORE, MODE_GEN, MODE_SHOW, MODE_CALC, MODE_SETUP: begin
                if ((back_pulse || pend_q) && !sub_busy) begin
                    mode_d = MODE_DEFAULT;
                    exit_d = 1'b1;
                    pend_d = 1'b0;
                end else if (back_pulse) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                // Encodings 6/7 are unreachable; recover silently.
                mode_d       = MODE_DEFAULT;
                pend_d       = 1'b0;
                w_err_cancel = 1'b1;
            end
        endcase
    end

    // Mode register, pending-back flag and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_DEFAULT;
            pend_q  <= 1'b0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    mode_fsm_blink_timer #(
        .BLINK_HALF  (BLINK_HALF),
        .ERR_TOGGLES (ERR_TOGGLES)
    ) u_blink_timer (
        .clk      (clk),
        .rst      (rst),
        .start_i  (w_err_start),
        .cancel_i (w_err_cancel),
        .blink_o  (w_err_blink),
        .active_o (w_err_active)
    );

    assign mode_state   = mode_q;
    assign error_active = w_err_active;
    assign blink_bit    = w_err_blink;
    assign mode_enter   = enter_q;
    assign mode_exit    = exit_q;

endmodule
`default_nettype wire

// File: tb/tb_mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mode_fsm
//  Purpose  : Self-checking bench for mode_fsm: directed scenarios followed by
//             randomized traffic, every cycle compared to a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mode_fsm;

    localparam int BH = 4;
    localparam int ET = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] mode_sw = '0;
    logic       confirm_pulse = 1'b0;
    logic       back_pulse = 1'b0;
    logic       sub_busy = 1'b0;
    logic [2:0] mode_state;
    logic       error_active;
    logic       blink_bit;
    logic       mode_enter;
    logic       mode_exit;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: mode number, error flag with elapsed-cycle count,
    // pending-back flag and the two pulses.
    int m_mode  = 0;
    bit m_err   = 0;
    int m_el    = 0;
    bit m_pend  = 0;
    bit m_enter = 0;
    bit m_exit  = 0;

    mode_fsm #(
        .BLINK_HALF  (BH),
        .ERR_TOGGLES (ET)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_sw       (mode_sw),
        .confirm_pulse (confirm_pulse),
        .back_pulse    (back_pulse),
        .sub_busy      (sub_busy),
        .mode_state    (mode_state),
        .error_active  (error_active),
        .blink_bit     (blink_bit),
        .mode_enter    (mode_enter),
        .mode_exit     (mode_exit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input logic [4:0] sw, input bit c,
                                input bit b, input bit bz);
        m_enter = 0;
        m_exit  = 0;
        if (r) begin
            m_mode = 0; m_err = 0; m_el = 0; m_pend = 0;
        end else if (m_mode == 0) begin
            if (b) begin
                m_err = 0;
            end else if (m_err) begin
                m_el++;
                if (m_el == BH * ET) m_err = 0;
            end else if (c) begin
                if ($countones(sw) == 1) begin
                    for (int i = 0; i < 5; i++)
                        if (sw[i]) m_mode = i + 1;
                    m_enter = 1;
                end else begin
                    m_err = 1;
                    m_el  = 0;
                end
            end
        end else begin
            if ((b || m_pend) && !bz) begin
                m_mode = 0; m_exit = 1; m_pend = 0;
            end else if (b) begin
                m_pend = 1;
            end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 ns later.
    task automatic step(input bit r, input logic [4:0] sw, input bit c,
                        input bit b, input bit bz);
        rst = r; mode_sw = sw; confirm_pulse = c; back_pulse = b; sub_busy = bz;
        @(posedge clk);
        model_update(r, sw, c, b, bz);
        #1;
        check_val("mode_state", int'(mode_state), m_mode);
        check_val("error_active", int'(error_active), int'(m_err));
        check_val("blink_bit", int'(blink_bit),
                  int'(m_err && (((m_el / BH) % 2) == 0)));
        check_val("mode_enter", int'(mode_enter), int'(m_enter));
        check_val("mode_exit", int'(mode_exit), int'(m_exit));
    endtask

    task automatic idle(input int n, input bit bz);
        for (int i = 0; i < n; i++) step(0, 5'b0, 0, 0, bz);
    endtask

    initial begin
        int err_len;
        bit busy;

        // 1: reset, then select SHOW
        step(1, 5'b0, 0, 0, 0);
        step(1, 5'b0, 0, 0, 0);
        step(0, 5'b00100, 1, 0, 0);
        check_val("t1_mode_show", int'(mode_state), 3);
        idle(2, 0);
        step(0, 5'b0, 0, 1, 0);

        // 2: invalid multi-bit selection, full error duration
        step(0, 5'b00110, 1, 0, 0);
        err_len = 0;
        while (error_active && err_len < 40) begin
            step(0, 5'b0, 0, 0, 0);
            err_len++;
        end
        check_val("t2_err_len", err_len, BH * ET);

        // 3: error cancelled by back, then select SETUP
        step(0, 5'b0, 1, 0, 0);
        idle(4, 0);
        step(0, 5'b0, 0, 1, 0);
        check_val("t3_err_cleared", int'(error_active), 0);
        step(0, 5'b10000, 1, 0, 0);
        check_val("t3_mode_setup", int'(mode_state), 5);
        step(0, 5'b0, 0, 1, 0);

        // 4: deferred exit from CALC while busy
        step(0, 5'b01000, 1, 0, 0);
        step(0, 5'b0, 0, 1, 1);
        idle(9, 1);
        step(0, 5'b0, 0, 1, 1);
        check_val("t4_still_calc", int'(mode_state), 4);
        step(0, 5'b0, 0, 0, 0);
        check_val("t4_exit", int'(mode_exit), 1);
        idle(1, 0);

        // 5: confirm and back together, then empty selection
        step(0, 5'b00001, 1, 1, 0);
        step(0, 5'b00000, 1, 0, 0);
        check_val("t5_err_start", int'(error_active), 1);
        idle(3, 0);

        // 6: reset mid-error, then reset mid-mode with pending back
        step(1, 5'b0, 0, 0, 0);
        step(0, 5'b00010, 1, 0, 1);
        step(0, 5'b0, 0, 1, 1);
        step(1, 5'b0, 0, 0, 1);
        idle(3, 0);
        check_val("t6_no_exit", int'(mode_state), 0);

        // Randomized traffic
        busy = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] sw;
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            if ($urandom_range(0, 9) < 7) sw = 5'b00001 << $urandom_range(0, 4);
            else                          sw = 5'($urandom);
            step($urandom_range(0, 299) == 0, sw,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, busy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
